// File: rtl/imm_gen_pkg.sv
// Shared definitions for the pipelined immediate generator: RV opcodes,
// shift funct3 codes and the one-hot instruction format encoding.
package imm_gen_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRX = 3'b101;

  // One-hot {J,U,B,S,I,R}; all-zero marks an unsupported opcode.
  typedef logic [5:0] fmt_t;
  localparam fmt_t FMT_NONE = 6'b000000;
  localparam fmt_t FMT_R    = 6'b000001;
  localparam fmt_t FMT_I    = 6'b000010;
  localparam fmt_t FMT_S    = 6'b000100;
  localparam fmt_t FMT_B    = 6'b001000;
  localparam fmt_t FMT_U    = 6'b010000;
  localparam fmt_t FMT_J    = 6'b100000;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Valid/ready bus of the immediate generator: instruction+tag in,
// immediate/format/illegal+tag out.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [5:0]       out_fmt;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_instr, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );

  modport slave (
    input  in_valid, in_instr, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );
endinterface

// File: rtl/imm_decode.sv
// Combinational RV immediate decoder: opcode -> format, XLEN-wide
// sign-extended immediate (zero-extended shamt for OP-IMM shifts) and
// an illegal flag for opcodes outside the supported set.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int EN_SHAMT = 1
) (
  input  logic                   instr_p0_i_unused_guard,
  input  logic [31:0]            instr,
  output logic signed [XLEN-1:0] imm,
  output fmt_t                   fmt,
  output logic                   illegal
);

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic               is_shift;
  logic [5:0]         shamt;
  logic signed [11:0] imm_i;
  logic signed [11:0] imm_s;
  logic signed [12:0] imm_b;
  logic signed [31:0] imm_u;
  logic signed [20:0] imm_j;

  function automatic logic signed [XLEN-1:0] zext_shamt(input logic [5:0] sh);
    return XLEN'(sh);
  endfunction

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign is_shift = (EN_SHAMT != 0) && (funct3 == F3_SLL || funct3 == F3_SRX);
  // RV64 shifts carry a 6-bit shamt; RV32 only 5 bits, bit 25 is funct7.
  assign shamt    = (XLEN == 64) ? instr[25:20] : {1'b0, instr[24:20]};

  // Every field's top bit is instr[31], so sign-extending each signed
  // field to XLEN is sign extension from instruction bit 31.
  assign imm_i = instr[31:20];
  assign imm_s = {instr[31:25], instr[11:7]};
  assign imm_b = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Opcode decode with safe defaults (illegal path yields imm=0, fmt=0).
  always_comb begin
    imm     = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    unique case (opcode)
      OP_R: fmt = FMT_R;
      OP_IMM: begin
        fmt = FMT_I;
        imm = is_shift ? zext_shamt(shamt) : XLEN'(imm_i);
      end
      OP_LOAD, OP_JALR, OP_SYSTEM: begin
        fmt = FMT_I;
        imm = XLEN'(imm_i);
      end
      OP_STORE: begin
        fmt = FMT_S;
        imm = XLEN'(imm_s);
      end
      OP_BRANCH: begin
        fmt = FMT_B;
        imm = XLEN'(imm_b);
      end
      OP_LUI, OP_AUIPC: begin
        fmt = FMT_U;
        imm = XLEN'(imm_u);
      end
      OP_JAL: begin
        fmt = FMT_J;
        imm = XLEN'(imm_j);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: decode ahead of a one-entry output
// register backed by a one-entry skid, so both producer and consumer
// can stall without bubbles and ordering stays FIFO.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int TAG_W    = 32,
  parameter int EN_SHAMT = 1
) (
  input logic          clk,
  input logic          rst_n,
  imm_gen_pipe_if.slave bus
);

  logic signed [XLEN-1:0] imm_p0;
  fmt_t                   fmt_p0;
  logic                   ill_p0;

  logic                   vld_p1;
  logic signed [XLEN-1:0] imm_p1;
  fmt_t                   fmt_p1;
  logic                   ill_p1;
  logic [TAG_W-1:0]       tag_p1;

  logic                   skid_vld_p1;
  logic signed [XLEN-1:0] skid_imm_p1;
  fmt_t                   skid_fmt_p1;
  logic                   skid_ill_p1;
  logic [TAG_W-1:0]       skid_tag_p1;

  logic                   in_fire;
  logic                   out_load;

  imm_decode #(
    .XLEN     (XLEN),
    .EN_SHAMT (EN_SHAMT)
  ) u_decode (
    .instr_p0_i_unused_guard (1'b0),
    .instr                   (bus.in_instr),
    .imm                     (imm_p0),
    .fmt                     (fmt_p0),
    .illegal                 (ill_p0)
  );

  // in_ready is the registered skid-empty flag, so it never depends on out_ready.
  assign in_fire  = bus.in_valid && !skid_vld_p1;
  assign out_load = !vld_p1 || bus.out_ready;

  // ---- stage p0 -> p1: output register and skid entry ----
  // Output register refills from the skid first (older), else from the input;
  // an input accepted while the output is stalled parks in the skid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      imm_p1      <= '0;
      fmt_p1      <= FMT_NONE;
      ill_p1      <= 1'b0;
      tag_p1      <= '0;
      skid_vld_p1 <= 1'b0;
      skid_imm_p1 <= '0;
      skid_fmt_p1 <= FMT_NONE;
      skid_ill_p1 <= 1'b0;
      skid_tag_p1 <= '0;
    end else if (out_load) begin
      if (skid_vld_p1) begin
        vld_p1      <= 1'b1;
        imm_p1      <= skid_imm_p1;
        fmt_p1      <= skid_fmt_p1;
        ill_p1      <= skid_ill_p1;
        tag_p1      <= skid_tag_p1;
        skid_vld_p1 <= 1'b0;
      end else begin
        vld_p1 <= in_fire;
        if (in_fire) begin
          imm_p1 <= imm_p0;
          fmt_p1 <= fmt_p0;
          ill_p1 <= ill_p0;
          tag_p1 <= bus.in_tag;
        end
      end
    end else if (in_fire) begin
      skid_vld_p1 <= 1'b1;
      skid_imm_p1 <= imm_p0;
      skid_fmt_p1 <= fmt_p0;
      skid_ill_p1 <= ill_p0;
      skid_tag_p1 <= bus.in_tag;
    end
  end

  assign bus.in_ready    = !skid_vld_p1;
  assign bus.out_valid   = vld_p1;
  assign bus.out_imm     = imm_p1;
  assign bus.out_fmt     = fmt_p1;
  assign bus.out_illegal = ill_p1;
  assign bus.out_tag     = tag_p1;

endmodule
